// File: rtl/dot_channel_seq_18_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dot_channel_seq_18_pkg                                     |
// | Desc    : Shared widths and FSM encodings for the dot-channel seq.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package dot_channel_seq_18_pkg;

    // Channel result width; mirrors `data_len of the channel datapath.
    localparam int c_DATA_LEN = 16;
    localparam int c_CS_W     = 4;
    localparam int c_PH_W     = 3;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_REQ  = 3'd1;
    localparam logic [2:0] c_ST_RUN  = 3'd2;
    localparam logic [2:0] c_ST_CAPT = 3'd3;
    localparam logic [2:0] c_ST_GAP  = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;

endpackage
`default_nettype wire

// File: rtl/dot_channel_seq_18_cs_phase_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dot_channel_seq_18_cs_phase_counter                        |
// | Desc    : (cs, phase) step counter; phase is the fast-moving digit.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dot_channel_seq_18_cs_phase_counter
    import dot_channel_seq_18_pkg::*;
#(
    parameter int CS_NUM    = 9,
    parameter int PHASE_NUM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [c_CS_W-1:0] cs,
    output logic [c_PH_W-1:0] phase,
    output logic              last
);

    localparam logic [c_CS_W-1:0] c_CS_LAST = c_CS_W'(CS_NUM - 1);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(PHASE_NUM - 1);

    logic [c_CS_W-1:0] r_cs;
    logic [c_PH_W-1:0] r_phase;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cs    <= '0;
            r_phase <= '0;
        end else if (advance) begin
            if (r_phase == c_PH_LAST) begin
                r_phase <= '0;
                r_cs    <= r_cs + 1'b1;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    assign cs    = r_cs;
    assign phase = r_phase;
    assign last  = (r_cs == c_CS_LAST) && (r_phase == c_PH_LAST);

endmodule
`default_nettype wire

// File: rtl/dot_channel_seq_18.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dot_channel_seq_18                                         |
// | Desc    : Steps one dot_channel_18 through every (cs, phase) of a    |
// |           layer, handshaking inputs and forwarding tagged results.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dot_channel_seq_18
    import dot_channel_seq_18_pkg::*;
#(
    parameter int CS_NUM    = 9,
    parameter int PHASE_NUM = 8,
    parameter int TIMEOUT   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_req,
    output logic [c_CS_W-1:0]     cs,
    output logic [c_PH_W-1:0]     phase,
    output logic                  ws_load,
    output logic                  dc_load,
    input  logic                  dc_valid,
    input  logic [c_DATA_LEN-1:0] dc_q,
    output logic                  out_valid,
    output logic [c_DATA_LEN-1:0] out_data,
    output logic [c_CS_W-1:0]     out_cs,
    output logic [c_PH_W-1:0]     out_phase,
    output logic                  step_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int               c_TO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [c_TO_W-1:0]     r_to_cnt;
    logic                  r_err;
    logic [c_DATA_LEN-1:0] r_out_data;
    logic [c_CS_W-1:0]     r_out_cs;
    logic [c_PH_W-1:0]     r_out_phase;
    logic                  w_start_acc;
    logic                  w_capture;
    logic                  w_timeout;
    logic                  w_last;
    logic                  w_advance;

    assign w_start_acc = (r_state == c_ST_IDLE) && start;
    assign w_capture   = (r_state == c_ST_RUN) && dc_valid;
    assign w_timeout   = (r_state == c_ST_RUN) && !dc_valid && (r_to_cnt == c_TO_LAST);
    // The final step leaves cs/phase parked on (CS_NUM-1, PHASE_NUM-1).
    assign w_advance   = (r_state == c_ST_GAP) && !w_last;

    dot_channel_seq_18_cs_phase_counter #(
        .CS_NUM    (CS_NUM),
        .PHASE_NUM (PHASE_NUM)
    ) u_step (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_start_acc),
        .advance (w_advance),
        .cs      (cs),
        .phase   (phase),
        .last    (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_next = c_ST_REQ;
            c_ST_REQ:  if (in_valid) w_next = c_ST_RUN;
            c_ST_RUN: begin
                if (dc_valid)                    w_next = c_ST_CAPT;
                else if (r_to_cnt == c_TO_LAST)  w_next = c_ST_DONE;
            end
            c_ST_CAPT: w_next = c_ST_GAP;
            c_ST_GAP:  w_next = w_last ? c_ST_DONE : c_ST_REQ;
            c_ST_DONE: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
            r_out_data  <= '0;
            r_out_cs    <= '0;
            r_out_phase <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == c_ST_REQ)
                r_to_cnt <= '0;
            else if (r_state == c_ST_RUN)
                r_to_cnt <= r_to_cnt + 1'b1;

            if (w_start_acc)
                r_err <= 1'b0;
            else if (w_timeout)
                r_err <= 1'b1;

            // Capture on the RUN cycle that sees dc_valid; presented during CAPT.
            if (w_capture) begin
                r_out_data  <= dc_q;
                r_out_cs    <= cs;
                r_out_phase <= phase;
            end
        end
    end

    assign in_req    = (r_state == c_ST_REQ);
    assign ws_load   = (r_state == c_ST_RUN) || (r_state == c_ST_CAPT);
    assign dc_load   = ws_load;
    assign out_valid = (r_state == c_ST_CAPT);
    assign step_done = (r_state == c_ST_CAPT);
    assign done      = (r_state == c_ST_DONE);
    assign busy      = (r_state != c_ST_IDLE);
    assign err       = r_err;
    assign out_data  = r_out_data;
    assign out_cs    = r_out_cs;
    assign out_phase = r_out_phase;

endmodule
`default_nettype wire

// File: tb/tb_dot_channel_seq_18.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dot_channel_seq_18                                      |
// | Desc    : Directed bench for dot_channel_seq_18 (2x2 steps, TO=8).   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_dot_channel_seq_18;
    import dot_channel_seq_18_pkg::*;

    localparam int CS_NUM    = 2;
    localparam int PHASE_NUM = 2;
    localparam int TIMEOUT   = 8;
    localparam int N_STEP    = CS_NUM * PHASE_NUM;
    localparam int CH_LAT    = 6;

    typedef struct {
        int          stall;
        logic [3:0]  cs;
        logic [2:0]  ph;
        logic [15:0] data;
    } vec_t;

    vec_t tbl [N_STEP];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        in_valid = 1'b1;
    logic        in_req;
    logic [3:0]  cs;
    logic [2:0]  phase;
    logic        ws_load;
    logic        dc_load;
    logic        dc_valid;
    logic [15:0] dc_q;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  out_cs;
    logic [2:0]  out_phase;
    logic        step_done;
    logic        busy;
    logic        done;
    logic        err;

    // bench controls, written only by the main initial block
    bit ch_en    = 1'b1;
    bit spur_en  = 1'b0;
    bit stall_en = 1'b0;
    bit poke_en  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // monitor-owned statistics
    logic [22:0] got_q [$];
    int done_cnt  = 0;
    int gap_viol  = 0;
    int load_viol = 0;
    int sd_viol   = 0;
    int req_len [N_STEP];
    bit seen_low  = 1'b1;
    int req_cyc   = 0;
    int ld_cnt    = 0;

    // snapshots taken at the start of each pass
    int b_got, b_done, b_gap, b_load, b_sd, b_req1;

    assign start    = start_a | start_b;
    assign dc_valid = (ch_en && ld_cnt >= CH_LAT) || (spur_en && in_req);
    assign dc_q     = 16'(17 * (int'(cs) * PHASE_NUM + int'(phase) + 1));

    always #5 clk = ~clk;

    dot_channel_seq_18 #(
        .CS_NUM    (CS_NUM),
        .PHASE_NUM (PHASE_NUM),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_req    (in_req),
        .cs        (cs),
        .phase     (phase),
        .ws_load   (ws_load),
        .dc_load   (dc_load),
        .dc_valid  (dc_valid),
        .dc_q      (dc_q),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_cs    (out_cs),
        .out_phase (out_phase),
        .step_done (step_done),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // channel model: valid CH_LAT cycles after both loads go high
    always @(posedge clk) begin
        if (ws_load && dc_load) ld_cnt <= ld_cnt + 1;
        else                    ld_cnt <= 0;
    end

    // upstream feature buffer: optional stall per step from the table
    always @(negedge clk) begin
        int idx;
        idx = int'(cs) * PHASE_NUM + int'(phase);
        if (in_req && stall_en && idx < N_STEP && req_cyc < tbl[idx].stall) begin
            in_valid = 1'b0;
            req_cyc++;
        end else begin
            in_valid = 1'b1;
        end
        if (!in_req) req_cyc = 0;
    end

    // start held high while the channel is loaded; must be ignored
    always @(negedge clk) start_b = poke_en && ws_load;

    always @(negedge clk) begin
        int idx;
        idx = int'(cs) * PHASE_NUM + int'(phase);
        if (out_valid) begin
            got_q.push_back({out_cs, out_phase, out_data});
            if (!seen_low) gap_viol++;
            seen_low = 1'b0;
        end
        if (!ws_load && !dc_load) seen_low = 1'b1;
        if (done) done_cnt++;
        if (in_req && (ws_load || dc_load)) load_viol++;
        if (out_valid !== step_done) sd_viol++;
        if (in_req && idx < N_STEP) req_len[idx]++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        b_got  = got_q.size();
        b_done = done_cnt;
        b_gap  = gap_viol;
        b_load = load_viol;
        b_sd   = sd_viol;
        b_req1 = req_len[1];
    endtask

    task automatic do_start();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == budget) check({tag, " done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic verify_pass(input string tag);
        logic [22:0] g;
        check({tag, " result_count"}, got_q.size() - b_got, N_STEP);
        for (int i = 0; i < N_STEP; i++) begin
            g = (b_got + i < got_q.size()) ? got_q[b_got + i] : 'x;
            check($sformatf("%s result%0d", tag, i), 32'(g),
                  32'({tbl[i].cs, tbl[i].ph, tbl[i].data}));
        end
        check({tag, " done_pulses"}, done_cnt - b_done, 1);
        check({tag, " load_gap"}, gap_viol - b_gap, 0);
        check({tag, " load_in_req"}, load_viol - b_load, 0);
        check({tag, " step_done"}, sd_viol - b_sd, 0);
        check({tag, " err"}, 32'(err), 0);
        check({tag, " busy_after"}, 32'(busy), 0);
    endtask

    task automatic run_pass(input string tag);
        snap();
        do_start();
        wait_done(tag, 600);
        verify_pass(tag);
    endtask

    initial begin
        int k;
        tbl[0] = '{0,  4'd0, 3'd0, 16'h0011};
        tbl[1] = '{10, 4'd0, 3'd1, 16'h0022};
        tbl[2] = '{0,  4'd1, 3'd0, 16'h0033};
        tbl[3] = '{0,  4'd1, 3'd1, 16'h0044};
        for (int i = 0; i < N_STEP; i++) req_len[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ctrl", 32'({in_req, ws_load, dc_load, out_valid, step_done, busy, done, err}), 0);
        check("reset tags", 32'({cs, phase, out_cs, out_phase}), 0);
        check("reset data", 32'(out_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle ctrl", 32'({in_req, ws_load, dc_load, out_valid, busy, done, err}), 0);

        // plain pass
        run_pass("passA");

        // stall on step (0,1), start pokes during RUN, spurious dc_valid in REQ
        stall_en = 1'b1; poke_en = 1'b1; spur_en = 1'b1;
        run_pass("passB");
        check("passB stall_req_len", req_len[1] - b_req1, 11);
        stall_en = 1'b0; poke_en = 1'b0; spur_en = 1'b0;

        // timeout: channel never answers
        ch_en = 1'b0;
        snap();
        do_start();
        for (k = 0; k < 40 && !ws_load; k++) @(negedge clk);
        check("to loads_seen", 32'(ws_load), 1);
        for (k = 0; k < 40 && !err; k++) @(negedge clk);
        check("to err_latency", k, TIMEOUT);
        check("to loads_dropped", 32'({ws_load, dc_load}), 0);
        check("to done_with_err", 32'(done), 1);
        repeat (3) @(negedge clk);
        check("to err_sticky", 32'(err), 1);
        check("to no_out_valid", got_q.size() - b_got, 0);
        check("to done_pulses", done_cnt - b_done, 1);
        ch_en = 1'b1;
        snap();
        do_start();
        @(negedge clk);
        check("to err_cleared", 32'({err, busy}), 32'b01);
        wait_done("after_to", 600);
        verify_pass("after_to");

        // reset asserted during CAPT
        snap();
        do_start();
        for (k = 0; k < 60 && !out_valid; k++) @(negedge clk);
        check("rst capt_reached", 32'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst ctrl", 32'({in_req, ws_load, dc_load, out_valid, step_done, busy, done, err}), 0);
        check("rst tags", 32'({cs, phase, out_cs, out_phase}), 0);
        check("rst data", 32'(out_data), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst no_done", done_cnt - b_done, 0);
        run_pass("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dot_channel_seq_18.md
Name: dot_channel_seq_18

Overview:
- Sequencer for one dot_channel_18 instance (36-wide dot product with weight_store_18).
- Walks every (cs, phase) step of a layer and drives ws_load/dc_load to that channel for each step.
- Handshakes per-step input vectors with the upstream feature buffer, waits for the channel's valid, and forwards each result downstream tagged with its step.
- Sits between the layer top-level controller (start/done) and the dot_channel_18 array.

Parameters:
- CS_NUM, 9, number of cs values per layer (cs = 0..CS_NUM-1, max 16).
- PHASE_NUM, 8, number of phases per cs (phase = 0..PHASE_NUM-1, max 8).
- TIMEOUT, 32, maximum cycles to wait for dc_valid after loads are asserted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse: begin a layer pass; ignored unless in IDLE.
- in_valid  in  1  upstream holds d for the requested step stable on the channel input.
- in_req  out  1  requesting the input vector for step (cs, phase).
- cs  out  4  current cs to the channel.
- phase  out  3  current phase to the channel.
- ws_load  out  1  to dot_channel_18.ws_load.
- dc_load  out  1  to dot_channel_18.dc_load.
- dc_valid  in  1  from dot_channel_18.valid.
- dc_q  in  `data_len  from dot_channel_18.q.
- out_valid  out  1  one-cycle pulse: result captured.
- out_data  out  `data_len  captured dc_q.
- out_cs  out  4  cs tag of out_data.
- out_phase  out  3  phase tag of out_data.
- step_done  out  1  pulse: upstream may change d.
- busy  out  1  high from the cycle after start until DONE is left.
- done  out  1  one-cycle pulse at end of pass.
- err  out  1  sticky timeout flag; cleared by rst or by an accepted start.

Behaviour:
- Reset values:
  - All outputs are 0, including cs, phase, out_data and the tags.
  - State is IDLE and the step counters are 0.
- States: IDLE, REQ, RUN, CAPT, GAP, DONE.
- IDLE:
  - On start, go to REQ next cycle.
  - cs and phase are set to 0, err is cleared, busy goes to 1.
- REQ:
  - in_req = 1; ws_load and dc_load = 0.
  - When in_valid = 1, go to RUN.
- RUN:
  - ws_load = dc_load = 1, held continuously; in_req = 0.
  - A timeout counter increments every cycle.
  - When dc_valid = 1, go to CAPT.
  - When the counter reaches TIMEOUT-1 without dc_valid: set err, drop the loads, go to DONE.
  - dc_valid is sampled only in RUN; it is ignored in all other states.
- CAPT (1 cycle):
  - Register out_data = dc_q (the value sampled in the RUN cycle where dc_valid was seen), with out_cs and out_phase.
  - out_valid = 1 and step_done = 1.
  - The loads stay 1 for this cycle.
- GAP (1 cycle):
  - ws_load = dc_load = 0, so the channel's inner counter and valid clear.
  - Advance the step: phase+1; when phase is PHASE_NUM-1, phase wraps to 0 and cs+1.
  - If the step just finished was (CS_NUM-1, PHASE_NUM-1), go to DONE and leave cs/phase unchanged; otherwise go to REQ.
- DONE (1 cycle): done = 1, busy = 0 from next cycle; return to IDLE.
- Minimum per-step overhead beyond channel latency: REQ ≥1, CAPT 1, GAP 1 cycle.
- in_valid is sampled only in REQ. If it drops during RUN, the data is still treated as valid; upstream must hold d until step_done.
- start while not in IDLE is ignored; no restart and no queuing.
- rst mid-pass:
  - Next cycle is IDLE with all outputs 0 and no out_valid or done.
  - Loads drop in the same edge.
- Width rules: cs/phase wrap compares against CS_NUM-1 and PHASE_NUM-1. The timeout counter is $clog2(TIMEOUT)+1 bits and is cleared on RUN entry.

Decomposition:
- Shared package/header holds the state encodings (localparam, 3-bit) and the cs/phase widths (4 and 3), alongside `data_len from num_data.v.
- One sub-module: cs_phase_counter.
  - Inputs: clear, advance.
  - Outputs: cs, phase, last (combinational: cs==CS_NUM-1 && phase==PHASE_NUM-1).
- FSM, timeout counter and output registers stay in dot_channel_seq_18.

Test Plan:
- Full pass, CS_NUM=2, PHASE_NUM=2; in_valid always 1; model dc_valid 6 cycles after loads with dc_q=0x11·(step+1) -> 4 out_valid pulses with (cs, phase, data) = (0,0,0x11), (0,1,0x22), (1,0,0x33), (1,1,0x44); ws_load/dc_load low ≥1 cycle between steps; one done pulse; err=0.
- Upstream stall: in_valid held 0 for 10 cycles in step (0,1) -> in_req stays 1, loads stay 0 throughout, then the step completes normally.
- Timeout, TIMEOUT=8; dc_valid never asserts -> err=1 exactly 8 cycles after RUN entry, loads drop, done pulse, no out_valid; a subsequent start clears err.
- start pulsed during RUN -> ignored; step count and result order unchanged; exactly 4 results.
- rst asserted in CAPT -> next cycle all outputs 0 and state IDLE; a new start reruns from (0,0).
- Spurious dc_valid=1 during REQ/GAP -> no capture and no out_valid.
